// File: rtl/count_mon_pkg.sv
// Shared constants and state type for the count sequence checkers.
package count_mon_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKED,
        ERROR
    } count_mon_state_t;

    function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] v);
        return v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/count_seq_monitor_if.sv
// Observation bus between the free-running counter side and the sequence monitor.
interface count_seq_monitor_if #(
    parameter int WRAP_W = 8
);
    import count_mon_pkg::*;

    logic [COUNT_W-1:0] count;
    logic               clr;
    logic               locked;
    logic               wrap;
    logic               err;
    logic               err_flag;
    logic [WRAP_W-1:0]  wrap_cnt;
    logic               wrap_ovf;

    modport master (
        output count, clr,
        input  locked, wrap, err, err_flag, wrap_cnt, wrap_ovf
    );

    modport slave (
        input  count, clr,
        output locked, wrap, err, err_flag, wrap_cnt, wrap_ovf
    );

endinterface

// File: rtl/count_step_chk.sv
// Combinational step decode: is count exactly prev+1 (mod 2^COUNT_W), and is that step a wrap.
module count_step_chk
    import count_mon_pkg::*;
(
    input  logic [COUNT_W-1:0] prev,
    input  logic               prev_vld,
    input  logic [COUNT_W-1:0] count,
    output logic               good,
    output logic               is_wrap
);

    assign good    = prev_vld && (count == count_next(prev));
    assign is_wrap = good && (prev == COUNT_MAX);

endmodule

// File: rtl/count_seq_monitor.sv
// Sequence monitor for the 4-bit free-running counter: lock, wrap counting, break detection.
// COUNT_SEQ_MONITOR_STICKY_ERR_EN: a break while locked parks the FSM in ERROR until clr/rst.
//
// state   | meaning
// ACQUIRE | counting consecutive good steps toward lock
// LOCKED  | tracking; wraps counted, any bad step reported
// ERROR   | parked after a break (sticky build only), waits for clr
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int WRAP_W   = 8
) (
    input logic              clk,
    input logic              rst,
    count_seq_monitor_if.slave bus
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT - 1);

    count_mon_state_t   state;
    logic [COUNT_W-1:0] prev;
    logic               prev_vld;
    logic [3:0]         run;
    logic               locked_q;
    logic               wrap_q;
    logic               err_q;
    logic               err_flag_q;
    logic [WRAP_W-1:0]  wrap_cnt_q;
    logic               wrap_ovf_q;
    logic               good;
    logic               is_wrap;

    count_step_chk u_step_chk (
        .prev     (prev),
        .prev_vld (prev_vld),
        .count    (bus.count),
        .good     (good),
        .is_wrap  (is_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ACQUIRE;
            prev       <= '0;
            prev_vld   <= 1'b0;
            run        <= '0;
            locked_q   <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            wrap_cnt_q <= '0;
            wrap_ovf_q <= 1'b0;
        end else begin
            prev   <= bus.count;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.clr) begin
                // prev_vld cleared so the next sample only seeds prev
                state      <= ACQUIRE;
                prev_vld   <= 1'b0;
                run        <= '0;
                locked_q   <= 1'b0;
                err_flag_q <= 1'b0;
                wrap_cnt_q <= '0;
                wrap_ovf_q <= 1'b0;
            end else begin
                prev_vld <= 1'b1;
                unique case (state)
                    ACQUIRE: begin
                        if (good) begin
                            if (run == LOCK_RUN) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                run      <= '0;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end else if (prev_vld) begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (is_wrap) begin
                            wrap_q     <= 1'b1;
                            wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
                            if (wrap_cnt_q == '1) wrap_ovf_q <= 1'b1;
                        end else if (!good) begin
                            err_q      <= 1'b1;
                            err_flag_q <= 1'b1;
                            locked_q   <= 1'b0;
                            run        <= '0;
`ifdef COUNT_SEQ_MONITOR_STICKY_ERR_EN
                            state      <= ERROR;
`else
                            state      <= ACQUIRE;
`endif
                        end
                    end
                    ERROR: begin
                    end
                    default: begin
                        state    <= ACQUIRE;
                        locked_q <= 1'b0;
                        run      <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked   = locked_q;
    assign bus.wrap     = wrap_q;
    assign bus.err      = err_q;
    assign bus.err_flag = err_flag_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.wrap_ovf = wrap_ovf_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: a WRAP_W=8 instance and a WRAP_W=2 instance watch the same counter.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] cur = 4'd0;
    logic [7:0] exp_wc;

    count_seq_monitor_if #(.WRAP_W(8)) b8 ();
    count_seq_monitor_if #(.WRAP_W(2)) b2 ();

    assign b2.count = b8.count;
    assign b2.clr   = b8.clr;

    count_seq_monitor #(.LOCK_CNT(4), .WRAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    count_seq_monitor #(.LOCK_CNT(4), .WRAP_W(2)) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] c, input logic cl);
        @(negedge clk);
        b8.count = c;
        b8.clr   = cl;
        cur      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(cur + 4'd1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        b8.count = 4'd0;
        b8.clr = 1'b0;
        #12;
        checks++; if ({b8.locked, b8.wrap, b8.err, b8.err_flag, b8.wrap_ovf} !== 5'b0 || b8.wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_w8: flags=%b wrap_cnt=%0d exp 0", {b8.locked, b8.wrap, b8.err, b8.err_flag, b8.wrap_ovf}, b8.wrap_cnt); end
        checks++; if ({b2.locked, b2.wrap_ovf} !== 2'b0 || b2.wrap_cnt !== 2'd0) begin errors++; $display("FAIL reset_w2: locked/ovf=%b wrap_cnt=%0d exp 0", {b2.locked, b2.wrap_ovf}, b2.wrap_cnt); end
    endtask

    task automatic test_lock();
        @(negedge clk);
        rst = 1'b1;
        b8.count = 4'd0;
        cur = 4'd0;
        @(posedge clk);
        #1;
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL lock_seed: locked=%b exp 0", b8.locked); end
        for (int k = 1; k <= 4; k++) begin
            step(4'(k), 1'b0);
            checks++; if (b8.locked !== (k == 4)) begin errors++; $display("FAIL lock_step%0d: locked=%b exp %b", k, b8.locked, (k == 4)); end
        end
        adv(11);
        checks++; if (b8.locked !== 1'b1 || b8.wrap !== 1'b0 || b8.wrap_cnt !== 8'd0) begin errors++; $display("FAIL pre_wrap: locked=%b wrap=%b wrap_cnt=%0d exp 1,0,0", b8.locked, b8.wrap, b8.wrap_cnt); end
        step(4'd0, 1'b0);
        checks++; if (b8.wrap !== 1'b1 || b8.wrap_cnt !== 8'd1 || b8.err !== 1'b0) begin errors++; $display("FAIL first_wrap: wrap=%b wrap_cnt=%0d err=%b exp 1,1,0", b8.wrap, b8.wrap_cnt, b8.err); end
        checks++; if (b2.wrap_cnt !== 2'd1) begin errors++; $display("FAIL first_wrap_w2: wrap_cnt=%0d exp 1", b2.wrap_cnt); end
        step(4'd1, 1'b0);
        checks++; if (b8.wrap !== 1'b0 || b8.wrap_cnt !== 8'd1) begin errors++; $display("FAIL wrap_pulse_end: wrap=%b wrap_cnt=%0d exp 0,1", b8.wrap, b8.wrap_cnt); end
    endtask

    task automatic test_err_jump();
        adv(5);
        checks++; if (b8.locked !== 1'b1) begin errors++; $display("FAIL jump_pre: locked=%b exp 1", b8.locked); end
        step(4'd9, 1'b0);
        checks++; if (b8.err !== 1'b1 || b8.err_flag !== 1'b1 || b8.locked !== 1'b0 || b8.wrap_cnt !== 8'd1) begin errors++; $display("FAIL jump_err: err=%b err_flag=%b locked=%b wrap_cnt=%0d exp 1,1,0,1", b8.err, b8.err_flag, b8.locked, b8.wrap_cnt); end
        step(4'd10, 1'b0);
        checks++; if (b8.err !== 1'b0 || b8.err_flag !== 1'b1 || b8.locked !== 1'b0) begin errors++; $display("FAIL jump_after: err=%b err_flag=%b locked=%b exp 0,1,0", b8.err, b8.err_flag, b8.locked); end
`ifdef COUNT_SEQ_MONITOR_STICKY_ERR_EN
        adv(3);
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL sticky_hold: locked=%b exp 0", b8.locked); end
        step(cur + 4'd1, 1'b1);
        checks++; if (b8.err_flag !== 1'b0 || b8.wrap_cnt !== 8'd0 || b8.locked !== 1'b0) begin errors++; $display("FAIL sticky_clr: err_flag=%b wrap_cnt=%0d locked=%b exp 0,0,0", b8.err_flag, b8.wrap_cnt, b8.locked); end
        adv(4);
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL sticky_relock_early: locked=%b exp 0", b8.locked); end
        adv(1);
        checks++; if (b8.locked !== 1'b1) begin errors++; $display("FAIL sticky_relock: locked=%b exp 1", b8.locked); end
`else
        adv(2);
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL relock_early: locked=%b exp 0", b8.locked); end
        adv(1);
        checks++; if (b8.locked !== 1'b1 || b8.err_flag !== 1'b1) begin errors++; $display("FAIL relock: locked=%b err_flag=%b exp 1,1", b8.locked, b8.err_flag); end
`endif
    endtask

    task automatic test_upstream_reset();
        logic [3:0] d;
`ifdef COUNT_SEQ_MONITOR_STICKY_ERR_EN
        exp_wc = 8'd0;
`else
        exp_wc = 8'd2;
`endif
        d = 4'd12 - cur;
        adv(int'(d));
        checks++; if (b8.locked !== 1'b1 || b8.wrap_cnt !== exp_wc) begin errors++; $display("FAIL ureset_pre: locked=%b wrap_cnt=%0d exp 1,%0d", b8.locked, b8.wrap_cnt, exp_wc); end
        step(4'd0, 1'b0);
        checks++; if (b8.err !== 1'b1 || b8.wrap !== 1'b0 || b8.locked !== 1'b0 || b8.wrap_cnt !== exp_wc) begin errors++; $display("FAIL ureset_err: err=%b wrap=%b locked=%b wrap_cnt=%0d exp 1,0,0,%0d", b8.err, b8.wrap, b8.locked, b8.wrap_cnt, exp_wc); end
        adv(3);
        checks++; if (b8.locked !== 1'b0 || b8.err !== 1'b0) begin errors++; $display("FAIL ureset_early: locked=%b err=%b exp 0,0", b8.locked, b8.err); end
        adv(1);
`ifdef COUNT_SEQ_MONITOR_STICKY_ERR_EN
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL ureset_sticky: locked=%b exp 0", b8.locked); end
`else
        checks++; if (b8.locked !== 1'b1 || b8.wrap_cnt !== exp_wc) begin errors++; $display("FAIL ureset_relock: locked=%b wrap_cnt=%0d exp 1,%0d", b8.locked, b8.wrap_cnt, exp_wc); end
`endif
    endtask

    task automatic test_wrap_ovf();
        logic [3:0] d;
        step(cur + 4'd1, 1'b1);
        checks++; if (b8.wrap_cnt !== 8'd0 || b2.wrap_cnt !== 2'd0 || b2.wrap_ovf !== 1'b0 || b8.err_flag !== 1'b0 || b8.locked !== 1'b0) begin errors++; $display("FAIL ovf_clr: w8=%0d w2=%0d ovf=%b err_flag=%b locked=%b exp 0", b8.wrap_cnt, b2.wrap_cnt, b2.wrap_ovf, b8.err_flag, b8.locked); end
        adv(5);
        checks++; if (b8.locked !== 1'b1 || b2.locked !== 1'b1) begin errors++; $display("FAIL ovf_lock: locked=%b/%b exp 1/1", b8.locked, b2.locked); end
        for (int w = 1; w <= 4; w++) begin
            d = 4'd15 - cur;
            adv(int'(d));
            step(4'd0, 1'b0);
            checks++; if (b2.wrap !== 1'b1 || b2.wrap_cnt !== 2'(w) || b2.wrap_ovf !== (w == 4)) begin errors++; $display("FAIL ovf_w2_wrap%0d: wrap=%b wrap_cnt=%0d ovf=%b exp 1,%0d,%b", w, b2.wrap, b2.wrap_cnt, b2.wrap_ovf, 2'(w), (w == 4)); end
            checks++; if (b8.wrap_cnt !== 8'(w) || b8.wrap_ovf !== 1'b0) begin errors++; $display("FAIL ovf_w8_wrap%0d: wrap_cnt=%0d ovf=%b exp %0d,0", w, b8.wrap_cnt, b8.wrap_ovf, w); end
        end
    endtask

    task automatic test_clr_wrap();
        adv(15);
        checks++; if (b8.locked !== 1'b1) begin errors++; $display("FAIL clrw_pre: locked=%b exp 1", b8.locked); end
        step(4'd0, 1'b1);
        checks++; if (b8.wrap !== 1'b0 || b8.err !== 1'b0 || b8.wrap_cnt !== 8'd0 || b8.locked !== 1'b0 || b2.wrap_ovf !== 1'b0) begin errors++; $display("FAIL clrw_mask: wrap=%b err=%b wrap_cnt=%0d locked=%b ovf=%b exp 0", b8.wrap, b8.err, b8.wrap_cnt, b8.locked, b2.wrap_ovf); end
        step(4'd1, 1'b0);
        adv(3);
        checks++; if (b8.locked !== 1'b0 || b8.err !== 1'b0) begin errors++; $display("FAIL clrw_seed: locked=%b err=%b exp 0,0", b8.locked, b8.err); end
        adv(1);
        checks++; if (b8.locked !== 1'b1) begin errors++; $display("FAIL clrw_relock: locked=%b exp 1", b8.locked); end
    endtask

    task automatic test_async_reset();
        adv(10);
        step(4'd0, 1'b0);
        checks++; if (b8.wrap !== 1'b1 || b8.wrap_cnt !== 8'd1) begin errors++; $display("FAIL arst_pre: wrap=%b wrap_cnt=%0d exp 1,1", b8.wrap, b8.wrap_cnt); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({b8.locked, b8.wrap, b8.err, b8.err_flag, b8.wrap_ovf} !== 5'b0 || b8.wrap_cnt !== 8'd0 || b2.wrap_cnt !== 2'd0) begin errors++; $display("FAIL arst_clear: flags=%b wrap_cnt=%0d/%0d exp 0", {b8.locked, b8.wrap, b8.err, b8.err_flag, b8.wrap_ovf}, b8.wrap_cnt, b2.wrap_cnt); end
        @(negedge clk);
        rst = 1'b1;
        b8.count = 4'd0;
        cur = 4'd0;
        @(posedge clk);
        #1;
        checks++; if (b8.locked !== 1'b0) begin errors++; $display("FAIL arst_seed: locked=%b exp 0", b8.locked); end
        for (int k = 1; k <= 4; k++) begin
            step(4'(k), 1'b0);
            checks++; if (b8.locked !== (k == 4) || b8.err !== 1'b0) begin errors++; $display("FAIL arst_relock%0d: locked=%b err=%b exp %b,0", k, b8.locked, b8.err, (k == 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_err_jump();
        test_upstream_reset();
        test_wrap_ovf();
        test_clr_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
